// File: rtl/seven_seg_scan_decoder_if.sv
// Bus bundle for the 7-segment scan decoder: the observed multiplexed display
// lines (digit enables plus segments A..G) and the recovered frame outputs.
interface seven_seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    A;
  logic                    B;
  logic                    C;
  logic                    D;
  logic                    E;
  logic                    F;
  logic                    G;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic                    frame_valid;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_abort;

  // master drives the display bus and watches the results; slave is the decoder
  modport master (
    output digit_en, A, B, C, D, E, F, G,
    input  bcd_out, frame_valid, digit_err, frame_abort
  );

  modport slave (
    input  digit_en, A, B, C, D, E, F, G,
    output bcd_out, frame_valid, digit_err, frame_abort
  );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Recovers BCD digits from a multiplexed active-high 7-segment display bus,
// filtering scan glitches and emitting each complete frame atomically.
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_seg_scan_decoder_if.slave bus
);

  typedef enum logic {SYNC, COLLECT} state_t;

  localparam int                    IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0]      STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ALL_ONES   = '1;
  localparam logic [NUM_DIGITS-1:0] FIRST_BIT  = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0] in_en;
  logic [6:0]            in_seg;
  logic [NUM_DIGITS-1:0] s_en;
  logic [6:0]            s_seg;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  in_onehot;
  logic                  same;
  logic                  capture;
  logic [IDX_W-1:0]      cap_idx;
  logic [3:0]            cap_nib;
  logic                  cap_bad;

  state_t                state;
  state_t                state_next;
  logic [NUM_DIGITS-1:0] mask;
  logic [NUM_DIGITS-1:0] mask_next;
  logic                  complete;
  logic                  is_d0;
  logic                  write_en;
  logic                  transfer;
  logic                  abort;
  logic                  clear_err;

  logic [3:0]              shadow_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   shadow_err;
  logic [4*NUM_DIGITS-1:0] bcd_reg;
  logic [NUM_DIGITS-1:0]   err_reg;
  logic                    valid_reg;
  logic                    abort_reg;

  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1111110: res = 5'h00;
      7'b0110000: res = 5'h01;
      7'b1101101: res = 5'h02;
      7'b1111001: res = 5'h03;
      7'b0110011: res = 5'h04;
      7'b1011011: res = 5'h05;
      7'b1011111: res = 5'h06;
      7'b1110000: res = 5'h07;
      7'b1111111: res = 5'h08;
      7'b1111011: res = 5'h09;
      default:    res = 5'h1F;
    endcase
    return res;
  endfunction

  assign in_en  = bus.digit_en;
  assign in_seg = {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G};

  // Stability is judged on the value being sampled this edge against the one
  // already held, so a capture lands on the same edge the count reaches its goal.
  always_comb begin
    in_onehot = (in_en != '0) && ((in_en & (in_en - NUM_DIGITS'(1))) == '0);
    same      = in_onehot && (in_en == s_en) && (in_seg == s_seg);
    if (same) begin
      count_next = (count == STABLE_MAX) ? count : count + CNT_W'(1);
    end else begin
      count_next = in_onehot ? CNT_W'(1) : '0;
    end
    capture = (count_next == STABLE_MAX) && !(same && (count == STABLE_MAX));
  end

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (in_en[i]) cap_idx = IDX_W'(i);
    end
    {cap_bad, cap_nib} = decode_seg(in_seg);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_en  <= '0;
      s_seg <= '0;
      count <= '0;
    end else begin
      s_en  <= in_en;
      s_seg <= in_seg;
      count <= count_next;
    end
  end

  assign complete = (state == COLLECT) && (mask == ALL_ONES);
  assign is_d0    = capture && (cap_idx == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC: begin
        if (is_d0) state_next = COLLECT;
      end
      COLLECT: begin
        if (complete) begin
          state_next = is_d0 ? COLLECT : SYNC;
        end else if (capture && mask[cap_idx] && !is_d0) begin
          state_next = SYNC;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  // A capture coinciding with frame completion is judged by the SYNC rules,
  // so it can only open the next frame, never abort the finishing one.
  always_comb begin
    write_en  = 1'b0;
    transfer  = 1'b0;
    abort     = 1'b0;
    clear_err = 1'b0;
    mask_next = mask;
    case (state)
      SYNC: begin
        if (is_d0) begin
          write_en  = 1'b1;
          mask_next = FIRST_BIT;
        end
      end
      COLLECT: begin
        if (complete) begin
          transfer  = 1'b1;
          mask_next = '0;
          if (is_d0) begin
            write_en  = 1'b1;
            mask_next = FIRST_BIT;
          end
        end else if (capture) begin
          if (!mask[cap_idx]) begin
            write_en  = 1'b1;
            mask_next = mask | (FIRST_BIT << cap_idx);
          end else begin
            abort     = 1'b1;
            clear_err = 1'b1;
            mask_next = '0;
            if (is_d0) begin
              write_en  = 1'b1;
              mask_next = FIRST_BIT;
            end
          end
        end
      end
      default: mask_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask       <= '0;
      shadow_err <= '0;
      bcd_reg    <= '0;
      err_reg    <= '0;
      valid_reg  <= 1'b0;
      abort_reg  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) shadow_nib[i] <= '0;
    end else begin
      mask      <= mask_next;
      valid_reg <= transfer;
      abort_reg <= abort;
      if (clear_err) shadow_err <= '0;
      if (write_en) begin
        shadow_nib[cap_idx] <= cap_nib;
        shadow_err[cap_idx] <= cap_bad;
      end
      if (transfer) begin
        for (int i = 0; i < NUM_DIGITS; i++) bcd_reg[4*i +: 4] <= shadow_nib[i];
        err_reg <= shadow_err;
      end
    end
  end

  assign bus.bcd_out     = bcd_reg;
  assign bus.digit_err   = err_reg;
  assign bus.frame_valid = valid_reg;
  assign bus.frame_abort = abort_reg;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench for seven_seg_scan_decoder: table-driven frames plus
// hand-written glitch, duplicate/abort and mid-frame reset sequences.
module tb_seven_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 3;

  typedef struct {
    int          kind;
    logic [15:0] bcd;
    logic [3:0]  err;
  } exp_t;

  typedef struct {
    logic [6:0]  seg [4];
    logic [15:0] bcd;
    logic [3:0]  err;
  } vec_t;

  localparam int EV_VALID = 1;
  localparam int EV_ABORT = 2;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   cycle;
  int   valid_seen;
  int   abort_seen;
  int   exp_valid;
  int   exp_abort;
  int   last_valid_cycle;
  exp_t exp_q [$];
  vec_t vecs [4];

  seven_seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_decoder #(
    .NUM_DIGITS(ND),
    .STABLE_CYCLES(SC),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [6:0] segOf(input int n);
    logic [6:0] tbl [10];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    return tbl[n];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [ND-1:0] en, input logic [6:0] seg, input int n);
    bus.digit_en = en;
    {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G} = seg;
    repeat (n) @(negedge clk);
  endtask

  // one dwell of 8 cycles followed by 2 cycles of blanking; k is the edge that first samples it
  task automatic scanDigit(input int idx, input logic [6:0] seg, output int k);
    k = cycle + 1;
    applyStimulus(ND'(1) << idx, seg, 8);
    applyStimulus('0, 7'b0000000, 2);
  endtask

  task automatic pushExp(input int kind, input logic [15:0] bcd, input logic [3:0] err);
    exp_t e;
    e.kind = kind;
    e.bcd  = bcd;
    e.err  = err;
    exp_q.push_back(e);
    if (kind == EV_VALID) exp_valid++;
    else                  exp_abort++;
  endtask

  // scoreboard: every output pulse must match the next expected event
  always @(negedge clk) begin
    exp_t e;
    if (bus.frame_valid === 1'b1 && bus.frame_abort === 1'b1)
      checkOutput("valid_and_abort", 32'd1, 32'd0);
    if (bus.frame_valid === 1'b1) begin
      valid_seen++;
      last_valid_cycle = cycle;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_kind", EV_VALID, e.kind);
        if (e.kind == EV_VALID) begin
          checkOutput("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
          checkOutput("digit_err", 32'(bus.digit_err), 32'(e.err));
        end
      end
    end
    if (bus.frame_abort === 1'b1) begin
      abort_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_abort", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_kind", EV_ABORT, e.kind);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    compared = 0; mismatched = 0; cycle = 0;
    valid_seen = 0; abort_seen = 0; exp_valid = 0; exp_abort = 0;
    last_valid_cycle = -1;

    vecs[0].seg = '{segOf(4), segOf(3), segOf(2), segOf(1)};
    vecs[0].bcd = 16'h1234; vecs[0].err = 4'b0000;
    vecs[1].seg = '{segOf(9), segOf(8), segOf(7), segOf(6)};
    vecs[1].bcd = 16'h6789; vecs[1].err = 4'b0000;
    vecs[2].seg = '{segOf(0), segOf(5), 7'b0000001, segOf(9)};
    vecs[2].bcd = 16'h9F50; vecs[2].err = 4'b0100;
    vecs[3].seg = '{7'b1000000, segOf(6), segOf(1), 7'b0011000};
    vecs[3].bcd = 16'hF16F; vecs[3].err = 4'b1001;

    // reset with random bus activity
    rst_n = 1'b0;
    bus.digit_en = '0;
    {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G} = '0;
    repeat (2) applyStimulus(ND'($urandom), 7'($urandom), 1);
    checkOutput("reset_bcd", 32'(bus.bcd_out), 32'd0);
    checkOutput("reset_valid", 32'(bus.frame_valid), 32'd0);
    checkOutput("reset_err", 32'(bus.digit_err), 32'd0);
    checkOutput("reset_abort", 32'(bus.frame_abort), 32'd0);
    rst_n = 1'b1;
    applyStimulus('0, 7'b0000000, 3);

    for (int v = 0; v < 4; v++) begin
      pushExp(EV_VALID, vecs[v].bcd, vecs[v].err);
      for (int d = 0; d < ND; d++) scanDigit(d, vecs[v].seg[d], k);
      checkOutput("latency", 32'(last_valid_cycle - k), 32'(SC));
    end
    applyStimulus('0, 7'b0000000, 5);
    checkOutput("hold_bcd", 32'(bus.bcd_out), 32'h0000F16F);
    checkOutput("hold_err", 32'(bus.digit_err), 32'h9);

    // glitch on digit 1 before its pattern settles
    pushExp(EV_VALID, 16'h7531, 4'b0000);
    scanDigit(0, segOf(1), k);
    applyStimulus(4'b0010, segOf(3), 2);
    applyStimulus(4'b0010, 7'b1111111, 2);
    applyStimulus(4'b0010, segOf(3), 5);
    applyStimulus('0, 7'b0000000, 2);
    scanDigit(2, segOf(5), k);
    scanDigit(3, segOf(7), k);

    // late start, then a duplicate digit 0 restarts the frame
    scanDigit(2, segOf(4), k);
    scanDigit(3, segOf(4), k);
    checkOutput("late_start_quiet", 32'(valid_seen), 32'(exp_valid));
    pushExp(EV_ABORT, 16'h0, 4'h0);
    pushExp(EV_VALID, 16'h9625, 4'b0000);
    scanDigit(0, segOf(7), k);
    scanDigit(1, segOf(8), k);
    scanDigit(0, segOf(5), k);
    scanDigit(1, segOf(2), k);
    scanDigit(2, segOf(6), k);
    scanDigit(3, segOf(9), k);

    // reset mid-frame discards the partial frame
    scanDigit(0, segOf(3), k);
    scanDigit(1, segOf(3), k);
    rst_n = 1'b0;
    applyStimulus('0, 7'b0000000, 2);
    rst_n = 1'b1;
    checkOutput("midreset_bcd", 32'(bus.bcd_out), 32'd0);
    scanDigit(2, segOf(3), k);
    scanDigit(3, segOf(3), k);
    checkOutput("midreset_quiet", 32'(valid_seen), 32'(exp_valid));
    pushExp(EV_VALID, 16'h0842, 4'b0000);
    scanDigit(0, segOf(2), k);
    scanDigit(1, segOf(4), k);
    scanDigit(2, segOf(8), k);
    scanDigit(3, segOf(0), k);

    applyStimulus('0, 7'b0000000, 10);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("valid_count", 32'(valid_seen), 32'(exp_valid));
    checkOutput("abort_count", 32'(abort_seen), 32'(exp_abort));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
